// File: rtl/tune_pkg.sv
// Shared definitions for the tune sequencer: FSM encoding, note word layout
// and the prescaler width helper.
package tune_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int PERIOD_MSB = 31;
    localparam int PERIOD_LSB = 8;
    localparam int DUR_MSB    = 7;

    function automatic int presc_w(input int div);
        if (div <= 2) return 1;
        return $clog2(div);
    endfunction

endpackage

// File: rtl/ms_ticker.sv
// Millisecond prescaler: one-cycle tick every DIV cycles while not cleared.
module ms_ticker #(
    parameter int DIV = 12000,
    parameter int W   = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tune_sequencer.sv
// Steps through a note RAM, driving a tone generator's period and gate with
// per-note millisecond durations and an optional silent gap between notes.
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int GAP_MS = 10
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       period_out,
    output logic              tone_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int              TICK_DIV = CLK_HZ / 1000;
    localparam int              PW       = presc_w(TICK_DIV);
    localparam logic [7:0]      GAP_CNT  = 8'(GAP_MS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx_nxt;
    logic [7:0]          ms_cnt, ms_nxt;
    logic [31:0]         period_nxt;
    logic                tone_nxt, done_nxt;
    logic                advance, end_tune;
    logic                tick, presc_clr;

    logic [31:0]         ram [DEPTH];
    logic [31:0]         ram_q;

    // Note RAM: writes only while idle, registered read every cycle
    always_ff @(posedge CLK) begin
        if (wr_en && state == S_IDLE) ram[wr_addr] <= wr_data;
        ram_q <= ram[note_idx];
    end

    assign presc_clr = !(state == S_PLAY || state == S_GAP);

    ms_ticker #(.DIV(TICK_DIV), .W(PW)) u_ticker (
        .clk   (CLK),
        .rst_n (RESETN),
        .clr   (presc_clr),
        .tick  (tick)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= S_IDLE;
            note_idx   <= '0;
            ms_cnt     <= '0;
            period_out <= '0;
            tone_en    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            note_idx   <= idx_nxt;
            ms_cnt     <= ms_nxt;
            period_out <= period_nxt;
            tone_en    <= tone_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = note_idx;
        ms_nxt     = ms_cnt;
        period_nxt = period_out;
        tone_nxt   = tone_en;
        done_nxt   = 1'b0;
        advance    = 1'b0;
        end_tune   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                end
            end
            S_FETCH: state_nxt = S_EVAL;
            S_EVAL: begin
                if (ram_q[DUR_MSB:0] == 8'd0) begin
                    end_tune = 1'b1;
                end else begin
                    period_nxt = {8'b0, ram_q[PERIOD_MSB:PERIOD_LSB]};
                    tone_nxt   = |ram_q[PERIOD_MSB:PERIOD_LSB];
                    ms_nxt     = ram_q[DUR_MSB:0];
                    state_nxt  = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (ms_cnt == 8'd1) begin
                        tone_nxt = 1'b0;
                        if (GAP_MS > 0) begin
                            state_nxt = S_GAP;
                            ms_nxt    = GAP_CNT;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        ms_nxt = ms_cnt - 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (ms_cnt == 8'd1) advance = 1'b1;
                    else                ms_nxt  = ms_cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (advance) begin
            if (note_idx == LAST_IDX) begin
                end_tune = 1'b1;
            end else begin
                idx_nxt   = note_idx + ADDR_W'(1);
                state_nxt = S_FETCH;
            end
        end

        if (end_tune) begin
            tone_nxt = 1'b0;
            if (loop) begin
                idx_nxt   = '0;
                state_nxt = S_FETCH;
            end else begin
                state_nxt  = S_IDLE;
                done_nxt   = 1'b1;
                period_nxt = '0;
            end
        end

        // Abort has priority over everything except an idle block
        if (stop && state != S_IDLE) begin
            state_nxt  = S_IDLE;
            tone_nxt   = 1'b0;
            period_nxt = '0;
            done_nxt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with a 4-cycle millisecond and 1 ms gap.
module tb_tune_sequencer;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        start, stop, loop, wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] period_out;
    logic        tone_en, busy, done;
    logic [2:0]  note_idx;

    int n_cmp = 0;
    int n_bad = 0;

    tune_sequencer #(.CLK_HZ(4000), .DEPTH(8), .ADDR_W(3), .GAP_MS(1)) dut (
        .CLK(CLK), .RESETN(RESETN), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .period_out(period_out), .tone_en(tone_en), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [31:0] period;
        logic        tone;
        logic        busy;
        logic        done;
        logic [2:0]  idx;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic write_note(input logic [2:0] a, input int per, input int dur);
        wr_en = 1'b1; wr_addr = a; wr_data = {24'(per), 8'(dur)};
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] p, input logic t,
                              input logic b, input logic d, input logic [2:0] i);
        check({tag, ".period"}, period_out, p);
        check({tag, ".tone"}, {31'b0, tone_en}, {31'b0, t});
        check({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
        check({tag, ".done"}, {31'b0, done}, {31'b0, d});
        check({tag, ".idx"}, {29'b0, note_idx}, {29'b0, i});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur;
        int dones;

        // {cycle after start, period, tone_en, busy, done, note_idx}
        tbl[0]  = '{1,  0,    0, 1, 0, 0};
        tbl[1]  = '{3,  1000, 1, 1, 0, 0};
        tbl[2]  = '{10, 1000, 1, 1, 0, 0};
        tbl[3]  = '{11, 1000, 0, 1, 0, 0};
        tbl[4]  = '{14, 1000, 0, 1, 0, 0};
        tbl[5]  = '{15, 1000, 0, 1, 0, 1};
        tbl[6]  = '{17, 80,   1, 1, 0, 1};
        tbl[7]  = '{20, 80,   1, 1, 0, 1};
        tbl[8]  = '{21, 80,   0, 1, 0, 1};
        tbl[9]  = '{25, 80,   0, 1, 0, 2};
        tbl[10] = '{27, 0,    0, 0, 1, 2};
        tbl[11] = '{28, 0,    0, 0, 0, 2};

        RESETN = 1'b0; start = 0; stop = 0; loop = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        #1;
        check_outs("reset", 0, 0, 0, 0, 0);
        step(2);
        RESETN = 1'b1;
        step(1);

        // Basic tune from the table
        write_note(0, 1000, 2);
        write_note(1, 80, 1);
        write_note(2, 0, 0);
        pulse_start();
        cur = 1;
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].cyc - cur);
            cur = tbl[k].cyc;
            check_outs($sformatf("tune[%0d]", tbl[k].cyc), tbl[k].period, tbl[k].tone,
                       tbl[k].busy, tbl[k].done, tbl[k].idx);
        end

        // Looping replays entry 0 with no done pulse
        loop = 1'b1;
        pulse_start();
        dones = 0;
        for (int c = 2; c <= 29; c++) begin
            step(1);
            if (done) dones++;
            if (c == 27) check_outs("loop.refetch", 80, 0, 1, 0, 0);
        end
        check_outs("loop.replay", 1000, 1, 1, 0, 0);
        check("loop.dones", dones, 0);
        stop = 1'b1; loop = 1'b0;
        step(1);
        stop = 1'b0;
        check_outs("loop.stop", 0, 0, 0, 0, 0);

        // Rest note is silent for 12 cycles, then the next entry plays
        write_note(0, 0, 3);
        pulse_start();
        step(2);
        check_outs("rest.first", 0, 0, 1, 0, 0);
        step(11);
        check_outs("rest.last", 0, 0, 1, 0, 0);
        step(7);
        check_outs("rest.next", 80, 1, 1, 0, 1);
        step(10);
        check_outs("rest.done", 0, 0, 0, 1, 2);

        // Stop mid-note aborts without done; start+stop together from idle ignored
        write_note(0, 1000, 2);
        pulse_start();
        step(4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_outs("stop.abort", 0, 0, 0, 0, 0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (done) dones++;
        end
        check("stop.dones", dones, 0);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check_outs("startstop.now", 0, 0, 0, 0, 0);
        step(3);
        check_outs("startstop.later", 0, 0, 0, 0, 0);

        // Full table: tune ends after the last entry; writes while busy are dropped
        for (int i = 0; i < 8; i++) write_note(3'(i), 100 + i, 1);
        pulse_start();
        step(4);
        wr_en = 1'b1; wr_addr = 0; wr_data = {24'd999, 8'd1};
        step(1);
        wr_en = 1'b0;
        step(7);
        check_outs("full.e1", 101, 1, 1, 0, 1);
        step(60);
        check_outs("full.e7", 107, 1, 1, 0, 7);
        step(8);
        check_outs("full.end", 0, 0, 0, 1, 7);
        pulse_start();
        step(2);
        check_outs("full.replay", 100, 1, 1, 0, 0);

        // Asynchronous reset mid-note, then a fresh start
        step(2);
        #2 RESETN = 1'b0;
        #1;
        check_outs("areset.now", 0, 0, 0, 0, 0);
        #8;
        check_outs("areset.hold", 0, 0, 0, 0, 0);
        RESETN = 1'b1;
        step(1);
        pulse_start();
        step(2);
        check_outs("areset.replay", 100, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
Plays a stored sequence of notes through one tone generator by driving its period input and a gate. Software (or a test top) loads a small note RAM, pulses start, and the block steps through entries, holding each note for a programmed number of milliseconds with an optional silent gap between notes. It sits between the board top and a tone instance, replacing fixed period registers with a timed schedule.

Parameters:
CLK_HZ, 12000000, system clock frequency; the millisecond tick is CLK_HZ/1000 cycles (must divide exactly, minimum 2)
DEPTH, 32, number of note RAM entries
ADDR_W, 5, note address width; DEPTH = 2**ADDR_W
GAP_MS, 10, silent gap between consecutive notes in ms; 0 means no gap state

Ports:
CLK  input  1  system clock, rising edge
RESETN  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins playback from entry 0
stop  input  1  single-cycle pulse; aborts playback
loop  input  1  level; sampled at end of tune; 1 means restart at entry 0
wr_en  input  1  note RAM write strobe
wr_addr  input  ADDR_W  note RAM write address
wr_data  input  32  {period[31:8], dur_ms[7:0]}; period in tone-generator units
period_out  output  32  period to tone instance, {8'b0, period}
tone_en  output  1  gate; 1 only while a non-rest note is sounding
busy  output  1  1 in any state other than IDLE
done  output  1  one-cycle pulse on natural end of tune (not on stop)
note_idx  output  ADDR_W  index of the current or last fetched entry

Behaviour:
- Reset (async, RESETN=0): state IDLE, period_out=0, tone_en=0, busy=0, done=0, note_idx=0, prescaler and ms counter cleared. RAM contents not reset (undefined until written).
- Writes: accepted only in IDLE; wr_en while busy is dropped silently. RAM read is registered (one-cycle latency).
- States: IDLE, FETCH, EVAL, PLAY, GAP.
- IDLE: on start (and stop low) -> FETCH with note_idx=0. start while busy ignored.
- FETCH: RAM read of note_idx issued -> EVAL next cycle.
- EVAL: if dur_ms==0, end of tune: loop=1 -> note_idx=0, FETCH; loop=0 -> IDLE, done=1 for that one cycle, period_out=0. Otherwise load period_out, tone_en=(period!=0) (period 0 is a rest: silent, timed normally), ms counter=dur_ms, prescaler=0 -> PLAY.
- Latency: start at cycle N -> period_out/tone_en valid from cycle N+3.
- PLAY: prescaler counts 0..CLK_HZ/1000-1; wrap generates ms tick; tick decrements ms counter. On tick with counter==1: GAP_MS>0 -> GAP (tone_en=0, period_out held, counter=GAP_MS, prescaler=0); else -> advance. A note occupies PLAY for exactly dur_ms*CLK_HZ/1000 cycles.
- GAP: same tick countdown; on final tick -> advance.
- Advance: if note_idx==DEPTH-1 treat as end of tune (same as dur_ms==0 path, loop sampled that cycle); else note_idx+1, FETCH.
- stop in any non-IDLE state: next state IDLE, tone_en=0, period_out=0, no done. stop and start same cycle: stop wins. stop in IDLE: no effect.
- RESETN asserted mid-note: immediate silence, all outputs to reset values.
- Counters: ms counter 8 bits (GAP_MS must be <=255); prescaler width clog2(CLK_HZ/1000).

Decomposition:
- Package tune_pkg: state encoding, field positions (PERIOD_MSB=31, PERIOD_LSB=8, DUR_MSB=7), helper function for prescaler width.
- One sub-module: ms_ticker (prescaler with synchronous clear input, emits one-cycle tick every CLK_HZ/1000 cycles). Note RAM inferred inline.

Test Plan:
(All with CLK_HZ=4000 -> tick=4 cycles, GAP_MS=1, DEPTH=8.)
- Load {1000,2},{80,1},{0,0 terminator} at 0..2, pulse start -> period_out=1000 for 8 cycles from start+3, gap 4 cycles tone_en=0, period 80 for 4 cycles, then done pulse once, busy=0, period_out=0.
- Same table, loop=1 -> after entry 1 and gap, note_idx returns 0 and period 1000 replays; no done pulse.
- Entry {0,3} rest -> tone_en=0 for 12 cycles, period_out=0, sequence continues to next entry.
- stop pulsed mid-note at cycle start+5 -> cycle after: state IDLE, tone_en=0, busy=0, done never asserted; start and stop same cycle from IDLE -> stays IDLE.
- All 8 entries non-zero duration -> after entry 7 tune ends with done (loop=0); wr_en during playback to addr 0 does not change replay value.
- RESETN low mid-PLAY for 1 cycle (async, off clock edge) -> outputs zero immediately; after release, start replays from entry 0.
